rampa_pwm: RTL

RAMPA_PWM -- requirements
Module: rampa_pwm

---
 rtl/rampa_pwm_pkg.sv | 22 ++
 rtl/rampa_pwm_if.sv | 22 ++
 rtl/rampa_pwm_contador.sv | 26 ++
 rtl/rampa_pwm.sv | 116 +++++++++++
 4 files changed

// File: rtl/rampa_pwm_pkg.sv
// Shared definitions for the PWM width ramp: FSM state encodings, default level limit
// and the target clamp helper.
package rampa_pwm_pkg;

    localparam int NIVEL_MAX_PADRAO = 4;
    localparam int LARGURA_W        = 3;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ESPERA = 2'd1,
        PASSO  = 2'd2,
        FIM    = 2'd3
    } estado_t;

    function automatic logic [LARGURA_W-1:0] limita_alvo(
        input logic [LARGURA_W-1:0] alvo,
        input logic [LARGURA_W-1:0] maximo
    );
        return (alvo > maximo) ? maximo : alvo;
    endfunction

endpackage

// File: rtl/rampa_pwm_if.sv
// Control/status bundle between the ramp requester (master) and rampa_pwm (slave).
interface rampa_pwm_if;
    import rampa_pwm_pkg::*;

    logic                 iniciar;
    logic [LARGURA_W-1:0] alvo;
    logic [LARGURA_W-1:0] largura;
    logic                 ocupado;
    logic                 pronto;
    logic [1:0]           db_estado;

    modport master (
        output iniciar, alvo,
        input  largura, ocupado, pronto, db_estado
    );

    modport slave (
        input  iniciar, alvo,
        output largura, ocupado, pronto, db_estado
    );

endinterface

// File: rtl/rampa_pwm_contador.sv
// contador_passo: 32-bit dwell counter; fim_passo flags the last cycle of a level step.
module contador_passo #(
    parameter int PASSO_CICLOS = 62500
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim_passo
);

    logic [31:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign fim_passo = enable && (r_count == 32'(PASSO_CICLOS - 1));

endmodule

// File: rtl/rampa_pwm.sv
// rampa_pwm: steps the PWM width select one level at a time toward a latched target.
// Optional macro RAMPA_PWM_PARADA_EN adds input parar (forced stop to level 0).
module rampa_pwm
    import rampa_pwm_pkg::*;
#(
    parameter int PASSO_CICLOS = 62500,
    parameter int NIVEL_MAX    = NIVEL_MAX_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
`ifdef RAMPA_PWM_PARADA_EN
    input  logic        parar,
`endif
    rampa_pwm_if.slave  ctrl
);

    localparam logic [LARGURA_W-1:0] NIVEL_MAX_C = LARGURA_W'(NIVEL_MAX);

    estado_t              r_estado;
    estado_t              w_proximo;
    logic [LARGURA_W-1:0] r_largura;
    logic [LARGURA_W-1:0] r_alvo;
    logic [LARGURA_W-1:0] w_alvo_limitado;
    logic [LARGURA_W-1:0] w_largura_passo;
    logic                 w_clear;
    logic                 w_enable;
    logic                 w_fim_passo;
    logic                 w_aceita;
    logic                 w_parar;

`ifdef RAMPA_PWM_PARADA_EN
    assign w_parar = parar;
`else
    assign w_parar = 1'b0;
`endif

    assign w_alvo_limitado = limita_alvo(ctrl.alvo, NIVEL_MAX_C);
    // ESPERA is only entered when target and level differ, so this never under/overflows
    assign w_largura_passo = (r_alvo > r_largura) ? (r_largura + 3'd1) : (r_largura - 3'd1);
    assign w_aceita        = (r_estado == OCIOSO) && ctrl.iniciar && !w_parar;

    contador_passo #(
        .PASSO_CICLOS (PASSO_CICLOS)
    ) u_contador (
        .clock     (clock),
        .reset     (reset),
        .clear     (w_clear),
        .enable    (w_enable),
        .fim_passo (w_fim_passo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo = r_estado;
        w_clear   = 1'b0;
        w_enable  = 1'b0;
        unique case (r_estado)
            OCIOSO: begin
                if (ctrl.iniciar) begin
                    w_clear   = 1'b1;
                    w_proximo = (w_alvo_limitado == r_largura) ? FIM : ESPERA;
                end
            end
            ESPERA: begin
                w_enable = 1'b1;
                if (w_fim_passo) begin
                    w_proximo = PASSO;
                end
            end
            PASSO: begin
                w_clear   = 1'b1;
                w_proximo = (w_largura_passo == r_alvo) ? FIM : ESPERA;
            end
            FIM: begin
                w_proximo = OCIOSO;
            end
            default: begin
                w_proximo = OCIOSO;
            end
        endcase
        if (w_parar) begin
            w_proximo = OCIOSO;
            w_clear   = 1'b1;
            w_enable  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_largura <= '0;
            r_alvo    <= '0;
        end else begin
            if (w_aceita) begin
                r_alvo <= w_alvo_limitado;
            end
            if (w_parar) begin
                r_largura <= '0;
            end else if (r_estado == PASSO) begin
                r_largura <= w_largura_passo;
            end
        end
    end

    assign ctrl.largura   = r_largura;
    assign ctrl.ocupado   = (r_estado == ESPERA) || (r_estado == PASSO);
    assign ctrl.pronto    = (r_estado == FIM);
    assign ctrl.db_estado = r_estado;

endmodule
